switch_led_controller: RTL and testbench

Owns the board's four LEDs and uses the four switches as debounced mode-select inputs. A switch press selects one of four display modes: pass-through, chase, blink or binary count. The controller sequences the LED pattern from a programmable step tick, and the top level drives the physical LED pins from it. All switch inputs are asynchronous to i_clk.

---
 rtl/switch_led_pkg.sv | 43 ++++
 rtl/switch_led_controller_debounce_filter.sv | 56 +++++
 rtl/switch_led_controller.sv | 102 ++++++++++
 tb/tb_switch_led_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_led_pkg
// Description : Shared mode encoding, LED pattern constants and pattern
//               stepping helpers for the switch/LED controller.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_led_pkg;

    localparam int LED_COUNT = 4;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_CHASE = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    localparam logic [LED_COUNT-1:0] CHASE_INIT   = 4'b0001;
    localparam logic [LED_COUNT-1:0] ZERO_PATTERN = '0;

    // Pattern loaded when a sequenced mode is (re)entered.
    function automatic logic [LED_COUNT-1:0] init_pattern(input mode_t mode);
        return (mode == MODE_CHASE) ? CHASE_INIT : ZERO_PATTERN;
    endfunction

    // Pattern after one step tick in a sequenced mode.
    function automatic logic [LED_COUNT-1:0] next_pattern(
        input mode_t                  mode,
        input logic [LED_COUNT-1:0]   pattern
    );
        logic [LED_COUNT-1:0] result;
        case (mode)
            MODE_CHASE: result = {pattern[LED_COUNT-2:0], pattern[LED_COUNT-1]};
            MODE_BLINK: result = ~pattern;
            MODE_COUNT: result = pattern + LED_COUNT'(1);
            default:    result = pattern;
        endcase
        return result;
    endfunction

endpackage : switch_led_pkg
`default_nettype wire

// File: rtl/switch_led_controller_debounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : debounce_filter
// Description : Two-flop synchroniser plus stability counter for one raw
//               switch; emits the debounced level and a one-cycle rise pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_filter #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam int                 CNT_W      = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             r_sync_meta;
    logic             r_sync;
    logic             r_stable;
    logic             r_rise;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
            r_stable    <= 1'b0;
            r_rise      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_sync_meta <= i_raw;
            r_sync      <= r_sync_meta;
            r_rise      <= 1'b0;
            if (r_sync == r_stable) begin
                r_count <= '0;
            end else if (r_count == C_CNT_LAST) begin
                // Accept the new level; the pulse is registered alongside it
                // so the arbiter sees the press on the very next edge.
                r_stable <= r_sync;
                r_rise   <= r_sync;
                r_count  <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;

endmodule : debounce_filter
`default_nettype wire

// File: rtl/switch_led_controller.sv
`default_nettype none
// ============================================================================
// Module      : switch_led_controller
// Description : Debounces four switches into mode selects and sequences the
//               four board LEDs (pass-through, chase, blink, binary count).
// Revision    : 1.0 - initial release
// ============================================================================
module switch_led_controller #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int STEP_LIMIT     = 6250000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_switch_1,
    input  logic       i_switch_2,
    input  logic       i_switch_3,
    input  logic       i_switch_4,
    output logic       o_led_1,
    output logic       o_led_2,
    output logic       o_led_3,
    output logic       o_led_4,
    output logic [1:0] o_mode
);

    import switch_led_pkg::*;

    localparam int                STEP_W      = $clog2(STEP_LIMIT);
    localparam logic [STEP_W-1:0] C_STEP_LAST = STEP_W'(STEP_LIMIT - 1);

    logic [LED_COUNT-1:0] w_raw;
    logic [LED_COUNT-1:0] w_stable;
    logic [LED_COUNT-1:0] w_rise;
    logic                 w_press;
    logic                 w_tick;
    mode_t                w_next_mode;

    mode_t                r_mode;
    logic [STEP_W-1:0]    r_step;
    logic [LED_COUNT-1:0] r_pattern;

    assign w_raw = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};

    generate
        for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_debounce
            debounce_filter #(
                .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
            ) u_debounce (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_raw    (w_raw[gi]),
                .o_stable (w_stable[gi]),
                .o_rise   (w_rise[gi])
            );
        end
    endgenerate

    // Fixed priority: the lowest-numbered switch wins a simultaneous press.
    always_comb begin
        w_press     = |w_rise;
        w_next_mode = r_mode;
        if (w_rise[0]) begin
            w_next_mode = MODE_PASS;
        end else if (w_rise[1]) begin
            w_next_mode = MODE_CHASE;
        end else if (w_rise[2]) begin
            w_next_mode = MODE_BLINK;
        end else if (w_rise[3]) begin
            w_next_mode = MODE_COUNT;
        end
    end

    assign w_tick = (r_step == C_STEP_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode    <= MODE_PASS;
            r_step    <= '0;
            r_pattern <= ZERO_PATTERN;
        end else if (w_press) begin
            // A press always restarts the sequence, even for the current mode.
            r_mode    <= w_next_mode;
            r_step    <= '0;
            r_pattern <= (w_next_mode == MODE_PASS) ? w_stable
                                                    : init_pattern(w_next_mode);
        end else begin
            r_step <= w_tick ? '0 : r_step + STEP_W'(1);
            if (r_mode == MODE_PASS) begin
                r_pattern <= w_stable;
            end else if (w_tick) begin
                r_pattern <= next_pattern(r_mode, r_pattern);
            end
        end
    end

    assign o_led_1 = r_pattern[0];
    assign o_led_2 = r_pattern[1];
    assign o_led_3 = r_pattern[2];
    assign o_led_4 = r_pattern[3];
    assign o_mode  = r_mode;

endmodule : switch_led_controller
`default_nettype wire

// File: tb/tb_switch_led_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_led_controller
// Description : Scoreboard bench for switch_led_controller with short
//               debounce and step limits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_led_controller;

    localparam int DEB  = 4;
    localparam int STEP = 3;
    localparam int LAT  = DEB + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       led_1, led_2, led_3, led_4;
    logic [1:0] mode;
    logic [3:0] led;

    assign led = {led_4, led_3, led_2, led_1};

    switch_led_controller #(
        .DEBOUNCE_LIMIT(DEB),
        .STEP_LIMIT    (STEP)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_switch_1 (sw[0]),
        .i_switch_2 (sw[1]),
        .i_switch_3 (sw[2]),
        .i_switch_4 (sw[3]),
        .o_led_1    (led_1),
        .o_led_2    (led_2),
        .o_led_3    (led_3),
        .o_led_4    (led_4),
        .o_mode     (mode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [1:0] mode;
        bit         chk_led;
        logic [3:0] led;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [3:0] chase_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    task automatic expect_at(input int at, input logic [1:0] m, input bit chk,
                             input logic [3:0] l, input string name);
        exp_t e;
        e.at = at; e.mode = m; e.chk_led = chk; e.led = l; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                n_checks++;
                if (sb[i].at < cyc) begin
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                             sb[i].name, sb[i].at, cyc);
                end else if (mode !== sb[i].mode ||
                             (sb[i].chk_led && led !== sb[i].led)) begin
                    $display("FAIL %s @cycle %0d: got mode=%0d led=%b, expected mode=%0d led=%b%s",
                             sb[i].name, cyc, mode, led, sb[i].mode, sb[i].led,
                             sb[i].chk_led ? "" : " (led not checked)");
                end else begin
                    n_pass++;
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, e, r, guard;

        // Reset with switches high: cleared on the first sampled edge.
        rst = 1'b1;
        sw  = 4'b1010;
        expect_at(1, 2'd0, 1'b1, 4'b0000, "reset_first_edge");
        expect_at(2, 2'd0, 1'b1, 4'b0000, "reset_held");
        wait_cyc(2);
        rst = 1'b0;
        sw  = 4'b0000;
        for (int c = 3; c <= 8; c++) expect_at(c, 2'd0, 1'b1, 4'b0000, "idle_after_reset");
        wait_cyc(8);

        // Bounce rejection, then a held press accepted 7 edges later.
        base = cyc;
        for (int c = 1; c <= 24; c++) expect_at(base + c, 2'd0, 1'b1, 4'b0000, "bounce_reject");
        expect_at(base + 25, 2'd0, 1'b1, 4'b0001, "bounce_accept");
        for (int p = 0; p < 3; p++) begin
            sw[0] = 1'b1;
            wait_cyc(cyc + 3);
            sw[0] = 1'b0;
            wait_cyc(cyc + 3);
        end
        sw[0] = 1'b1;
        wait_cyc(base + 26);

        // Chase entry and a full rotation.
        base = cyc;
        sw[1] = 1'b1;
        expect_at(base + LAT - 1, 2'd0, 1'b1, 4'b0001, "pre_chase");
        e = base + LAT;
        for (int k = 0; k <= 12; k++) expect_at(e + k, 2'd1, 1'b1, chase_tbl[(k / 3) % 4], "chase");
        wait_cyc(e + 12);

        // Binary count through the 15 -> 0 wrap.
        base = cyc;
        sw[3] = 1'b1;
        e = base + LAT;
        for (int k = 0; k <= 48; k++) expect_at(e + k, 2'd3, 1'b1, 4'((k / 3) % 16), "count");
        wait_cyc(e + 48);

        // Blink.
        base = cyc;
        sw[2] = 1'b1;
        e = base + LAT;
        for (int k = 0; k <= 12; k++)
            expect_at(e + k, 2'd2, 1'b1, ((k / 3) % 2 != 0) ? 4'b1111 : 4'b0000, "blink");
        wait_cyc(e + 12);

        // Releases produce no mode change.
        base = cyc;
        sw[0] = 1'b0;
        sw[1] = 1'b0;
        sw[2] = 1'b0;
        for (int c = 1; c <= 10; c++) expect_at(base + c, 2'd2, 1'b0, 4'b0000, "release_no_event");
        wait_cyc(base + 10);

        // Simultaneous presses of switches 2 and 3: switch 2 wins.
        base = cyc;
        sw[1] = 1'b1;
        sw[2] = 1'b1;
        expect_at(base + LAT - 1, 2'd2, 1'b0, 4'b0000, "simul_pre");
        e = base + LAT;
        for (int k = 0; k <= 24; k++) expect_at(e + k, 2'd1, 1'b1, chase_tbl[(k / 3) % 4], "simul_chase");
        wait_cyc(e + 3);
        sw[1] = 1'b0;
        sw[2] = 1'b0;
        wait_cyc(e + 24);

        // Re-arm switch 4, count to 0101, then reset mid-count.
        base = cyc;
        sw[3] = 1'b0;
        for (int c = 1; c <= 8; c++) expect_at(base + c, 2'd1, 1'b0, 4'b0000, "release_sw4");
        wait_cyc(base + 8);
        base = cyc;
        sw[3] = 1'b1;
        e = base + LAT;
        for (int k = 0; k <= 15; k++) expect_at(e + k, 2'd3, 1'b1, 4'((k / 3) % 16), "count_again");
        wait_cyc(e + 15);
        rst = 1'b1;
        r = e + 16;
        expect_at(r, 2'd0, 1'b1, 4'b0000, "reset_mid_count");
        wait_cyc(r);
        rst = 1'b0;
        for (int k = 1; k < LAT; k++) expect_at(r + k, 2'd0, 1'b1, 4'b0000, "reacquire_wait");
        expect_at(r + LAT,     2'd3, 1'b1, 4'b0000, "reacquire_count");
        expect_at(r + LAT + 3, 2'd3, 1'b1, 4'b0001, "reacquire_step");
        wait_cyc(r + LAT + 3);

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_switch_led_controller
`default_nettype wire
